// File: rtl/servo_sweep_scheduler_pkg.sv
// Shared types, timing defaults and the step-index to servo-position map
// for the radar sweep scheduler.
package servo_sweep_pkg;

  localparam int unsigned DEF_POS_W          = 3;
  localparam int unsigned DEF_SETTLE_CYCLES  = 50_000_000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 5_000_000;
  localparam int unsigned DEF_TMR_W          = 26;

  typedef enum logic [3:0] {
    ST_IDLE           = 4'd0,
    ST_POSICIONA      = 4'd1,
    ST_ESPERA         = 4'd2,
    ST_MEDE           = 4'd3,
    ST_AGUARDA_MEDIDA = 4'd4,
    ST_TIMEOUT        = 4'd5,
    ST_TRANSMITE      = 4'd6,
    ST_AGUARDA_ENVIO  = 4'd7,
    ST_PROXIMO        = 4'd8
  } estado_t;

  // Triangular sweep: rises 0..pico, then falls back towards 1.
  function automatic int unsigned pos_map(input int unsigned idx, input int unsigned pos_w);
    int unsigned pico;
    pico = (32'd1 << pos_w) - 32'd1;
    return (idx <= pico) ? idx : (2 * pico) - idx;
  endfunction

endpackage

// File: rtl/servo_sweep_scheduler_sweep_index_counter.sv
// Mod-N_POS step counter for the sweep, with wrap flag and the mapped
// servo position of the current step.
module sweep_index_counter
  import servo_sweep_pkg::*;
#(
  parameter int unsigned POS_W = DEF_POS_W
) (
  input  logic             clock,
  input  logic             zera_as_n,
  input  logic             avanca,
  output logic             wrap,
  output logic [POS_W-1:0] posicao_mapa
);

  localparam int unsigned N_POS = 2 * ((1 << POS_W) - 1);

  // N_POS < 2^(POS_W+1), so one extra bit always holds the index.
  logic [POS_W:0] idx;

  assign wrap         = (idx == (POS_W + 1)'(N_POS - 1));
  assign posicao_mapa = POS_W'(pos_map(32'(idx), POS_W));

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      idx <= '0;
    end else if (avanca) begin
      idx <= wrap ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/servo_sweep_scheduler.sv
// Sweep sequencer: position servo, settle, measure (with timeout), transmit
// the result, advance to the next position of the triangular sweep.
module servo_sweep_scheduler
  import servo_sweep_pkg::*;
#(
  parameter int unsigned POS_W          = DEF_POS_W,
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned TMR_W          = DEF_TMR_W
) (
  input  logic             clock,
  input  logic             zera_as_n,
  input  logic             ligar,
  input  logic             medida_pronto,
  input  logic             envio_pronto,
  output logic [POS_W-1:0] posicao,
  output logic             medir,
  output logic             transmitir,
  output logic             erro_timeout,
  output logic             fim_varredura,
  output logic [3:0]       db_estado
);

  localparam logic [TMR_W-1:0] SETTLE_FIM  = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_FIM = TMR_W'(TIMEOUT_CYCLES - 1);

  estado_t          estado, estado_prox;
  logic [TMR_W-1:0] timer;
  logic             avanca;
  logic             wrap;
  logic [POS_W-1:0] posicao_mapa;

  sweep_index_counter #(.POS_W(POS_W)) u_index (
    .clock        (clock),
    .zera_as_n    (zera_as_n),
    .avanca       (avanca),
    .wrap         (wrap),
    .posicao_mapa (posicao_mapa)
  );

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) estado <= ST_IDLE;
    else            estado <= estado_prox;
  end

  always_comb begin
    estado_prox   = estado;
    medir         = 1'b0;
    transmitir    = 1'b0;
    erro_timeout  = 1'b0;
    fim_varredura = 1'b0;
    avanca        = 1'b0;
    case (estado)
      ST_IDLE:           if (ligar) estado_prox = ST_POSICIONA;
      ST_POSICIONA:      estado_prox = ST_ESPERA;
      ST_ESPERA:         if (timer == SETTLE_FIM) estado_prox = ST_MEDE;
      ST_MEDE: begin
        medir       = 1'b1;
        estado_prox = ST_AGUARDA_MEDIDA;
      end
      // A result arriving on the last timeout cycle still counts.
      ST_AGUARDA_MEDIDA: begin
        if (medida_pronto)             estado_prox = ST_TRANSMITE;
        else if (timer == TIMEOUT_FIM) estado_prox = ST_TIMEOUT;
      end
      ST_TIMEOUT: begin
        erro_timeout = 1'b1;
        estado_prox  = ST_PROXIMO;
      end
      ST_TRANSMITE: begin
        transmitir  = 1'b1;
        estado_prox = ST_AGUARDA_ENVIO;
      end
      ST_AGUARDA_ENVIO:  if (envio_pronto) estado_prox = ST_PROXIMO;
      ST_PROXIMO: begin
        avanca        = 1'b1;
        fim_varredura = wrap;
        estado_prox   = ligar ? ST_POSICIONA : ST_IDLE;
      end
      default:           estado_prox = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      timer <= '0;
    end else begin
      case (estado)
        ST_POSICIONA, ST_MEDE: timer <= '0;
        ST_ESPERA:             timer <= timer + 1'b1;
        ST_AGUARDA_MEDIDA:     if (!medida_pronto && timer != TIMEOUT_FIM) timer <= timer + 1'b1;
        default:               timer <= timer;
      endcase
    end
  end

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n)                posicao <= '0;
    else if (estado == ST_POSICIONA) posicao <= posicao_mapa;
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_servo_sweep_scheduler.sv
// Scoreboard bench for servo_sweep_scheduler: planned sweep steps produce an
// expected event stream that a monitor consumes as the DUT pulses.
module tb_servo_sweep_scheduler;

  localparam int unsigned SETTLE    = 4;
  localparam int unsigned TMO       = 8;
  localparam int          NSTEPS    = 39;
  localparam int          RST_STEP  = 23;
  localparam int          DROP_STEP = 19;
  localparam int          SPUR_STEP = 21;
  localparam int          TMO_STEP  = 16;
  localparam int          EDGE_STEP = 17;
  localparam int          BUDGET    = 3000;

  logic       clock = 1'b0;
  logic       zera_as_n = 1'b0;
  logic       ligar = 1'b0;
  logic       medida_pronto = 1'b0;
  logic       resp_env = 1'b0;
  logic       spur_env = 1'b0;
  logic       envio_pronto;
  logic [2:0] posicao;
  logic       medir, transmitir, erro_timeout, fim_varredura;
  logic [3:0] db_estado;

  assign envio_pronto = resp_env | spur_env;

  servo_sweep_scheduler #(
    .POS_W          (3),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO),
    .TMR_W          (26)
  ) dut (
    .clock         (clock),
    .zera_as_n     (zera_as_n),
    .ligar         (ligar),
    .medida_pronto (medida_pronto),
    .envio_pronto  (envio_pronto),
    .posicao       (posicao),
    .medir         (medir),
    .transmitir    (transmitir),
    .erro_timeout  (erro_timeout),
    .fim_varredura (fim_varredura),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  typedef enum int {EV_MEDIR, EV_TX, EV_ERRO, EV_ENV, EV_FIM} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
  } ev_t;

  ev_t exp_q[$];
  int  seq[$];
  int  step_idx[NSTEPS];
  int  med_delay[NSTEPS];   // 0 means no answer in time
  int  env_delay[NSTEPS];
  int  n_after_reset = 0;
  int  checks = 0;
  int  errors = 0;
  int  med_count = 0;
  int  cur_step = 0;
  int  mc = 0;
  int  ec = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input int v, input int s);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
    if (s > RST_STEP) n_after_reset++;
  endtask

  task automatic pop_ev(input ev_kind_t k, input string name, output int val, output bit ok);
    ev_t e;
    val = 0;
    ok  = 1'b0;
    if (exp_q.size() == 0) begin
      check({name, " unexpected"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({name, " order"}, int'(e.kind), int'(k));
      ok  = (e.kind == k);
      val = e.val;
    end
  endtask

  // Reference plan: triangular position table and per-step response timing.
  task automatic build_model();
    for (int i = 0; i <= 7; i++) seq.push_back(i);
    for (int i = 6; i >= 1; i--) seq.push_back(i);
    for (int s = 0; s < NSTEPS; s++) begin
      step_idx[s] = (s <= RST_STEP) ? (s % 14) : ((s - RST_STEP - 1) % 14);
      if (s < 14) begin
        med_delay[s] = 2;
        env_delay[s] = 3;
      end else begin
        med_delay[s] = int'($urandom_range(8, 1));
        env_delay[s] = int'($urandom_range(5, 1));
        if (s > RST_STEP && $urandom_range(7, 0) == 0) med_delay[s] = 0;
      end
      if (s == TMO_STEP)  med_delay[s] = 0;
      if (s == EDGE_STEP) med_delay[s] = int'(TMO);
      push_ev(EV_MEDIR, seq[step_idx[s]], s);
      if (med_delay[s] == 0) begin
        push_ev(EV_ERRO, int'(TMO) + 1, s);
      end else begin
        push_ev(EV_TX, med_delay[s] + 1, s);
        if (s != RST_STEP) push_ev(EV_ENV, env_delay[s] + 1, s);
      end
      if (s != RST_STEP && step_idx[s] == 13) push_ev(EV_FIM, 0, s);
    end
  endtask

  // Responder: answers medir / transmitir after the planned delays.
  initial begin
    forever begin
      @(negedge clock);
      medida_pronto = 1'b0;
      resp_env      = 1'b0;
      if (!zera_as_n) begin
        mc = 0;
        ec = 0;
      end else begin
        if (mc > 0) begin
          mc--;
          if (mc == 0) medida_pronto = 1'b1;
        end
        if (ec > 0) begin
          ec--;
          if (ec == 0) resp_env = 1'b1;
        end
        if (medir) begin
          cur_step = med_count;
          med_count++;
          if (cur_step < NSTEPS)
            mc = (med_delay[cur_step] == 0) ? int'(TMO) + 1 : med_delay[cur_step];
          else
            mc = 1;
        end
        if (transmitir) ec = (cur_step < NSTEPS) ? env_delay[cur_step] : 1;
      end
    end
  end

  // Monitor: consumes the expected event stream as the DUT pulses.
  initial begin
    int  cyc = 0, medir_cyc = 0, tx_cyc = 0, espera_run = 0, prev = 0, v;
    bit  wait_env = 1'b0, ok;
    forever begin
      @(negedge clock);
      if (!zera_as_n) begin
        wait_env = 1'b0;
        prev     = 0;
      end else begin
        cyc++;
        if (db_estado == 4'd2) espera_run = (prev == 2) ? espera_run + 1 : 1;
        if (medir) begin
          pop_ev(EV_MEDIR, "medir", v, ok);
          if (ok) check("posicao at medir", int'(posicao), v);
          check("settle dwell", espera_run, int'(SETTLE));
          medir_cyc = cyc;
        end
        if (transmitir) begin
          pop_ev(EV_TX, "transmitir", v, ok);
          if (ok) check("medir->transmitir latency", cyc - medir_cyc, v);
          tx_cyc   = cyc;
          wait_env = 1'b1;
        end
        if (erro_timeout) begin
          pop_ev(EV_ERRO, "erro_timeout", v, ok);
          if (ok) check("medir->timeout latency", cyc - medir_cyc, v);
        end
        if (db_estado == 4'd8 && prev != 8 && wait_env) begin
          pop_ev(EV_ENV, "envio wait", v, ok);
          if (ok) check("transmitir->proximo latency", cyc - tx_cyc, v);
          wait_env = 1'b0;
        end
        if (fim_varredura) pop_ev(EV_FIM, "fim_varredura", v, ok);
        prev = int'(db_estado);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got %0d steps, expected %0d", med_count, NSTEPS);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    build_model();

    #12;
    check("reset db_estado", int'(db_estado), 0);
    check("reset posicao", int'(posicao), 0);
    check("reset pulses", int'({medir, transmitir, erro_timeout, fim_varredura}), 0);
    @(negedge clock);
    zera_as_n = 1'b1;
    ligar     = 1'b1;

    // Drop enable during the settle of one step; the step still completes.
    for (n = 0; n < BUDGET && !(med_count == DROP_STEP && db_estado == 4'd2); n++) @(negedge clock);
    check("reach drop point", int'(n < BUDGET), 1);
    ligar = 1'b0;
    for (n = 0; n < BUDGET && db_estado != 4'd0; n++) @(negedge clock);
    check("idle after drop", int'(db_estado), 0);
    repeat (4) @(negedge clock);
    check("idle held", int'(db_estado), 0);
    check("posicao held in idle", int'(posicao), seq[step_idx[DROP_STEP]]);
    check("step completed before idle", med_count, DROP_STEP + 1);
    ligar = 1'b1;

    // Spurious envio_pronto while settling must not be remembered.
    for (n = 0; n < BUDGET && !(med_count == SPUR_STEP && db_estado == 4'd2); n++) @(negedge clock);
    check("reach spurious point", int'(n < BUDGET), 1);
    spur_env = 1'b1;
    @(negedge clock);
    spur_env = 1'b0;

    // Asynchronous reset while waiting for the transmitter.
    for (n = 0; n < BUDGET && !(med_count == RST_STEP + 1 && db_estado == 4'd7); n++) @(negedge clock);
    check("reach reset point", int'(n < BUDGET), 1);
    #2 zera_as_n = 1'b0;
    #1;
    check("mid reset db_estado", int'(db_estado), 0);
    check("mid reset posicao", int'(posicao), 0);
    check("mid reset pulses", int'({medir, transmitir, erro_timeout, fim_varredura}), 0);
    check("events pending at reset", exp_q.size(), n_after_reset);
    @(negedge clock);
    @(negedge clock);
    zera_as_n = 1'b1;

    // Run the post-reset sweep, then stop at the end of the last step.
    for (n = 0; n < BUDGET && med_count < NSTEPS; n++) @(negedge clock);
    check("all steps measured", med_count, NSTEPS);
    ligar = 1'b0;
    for (n = 0; n < BUDGET && !(exp_q.size() == 0 && db_estado == 4'd0); n++) @(negedge clock);
    check("events remaining", exp_q.size(), 0);
    repeat (SETTLE + 4) @(negedge clock);
    check("final idle", int'(db_estado), 0);
    check("no extra steps", med_count, NSTEPS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
